lut_rom_lookup_pipe: RTL and testbench

Parametrised, pipelined constant-lookup ROM built from LUT6 primitives, replacing the fixed 32-entry, registered-output LUT6_2 ROM. It adds arbitrary depth through 64-entry LUT banks plus a registered bank mux, a valid/ready handshake with full backpressure, a sideband tag, out-of-range detection and a lookup counter. It sits in the ibf_pex parse path, mapping header-field indices to parser constants.

---
 rtl/ibf_pex_pkg.sv | 34 +++
 rtl/lut6_rom_bank.sv | 22 ++
 rtl/lut_rom_lookup_pipe.sv | 134 +++++++++++++
 tb/tb_lut_rom_lookup_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibf_pex_pkg.sv
// Shared helpers for the ibf_pex parse-path constant ROMs: bank count and
// per-bit LUT6 INIT derivation from a flattened entry table.
package ibf_pex_pkg;

    localparam int unsigned LUT_ENTRIES = 64;
    localparam int unsigned INIT_MAX_W  = 256 * 1024;

    // Number of 64-entry banks needed to hold depth entries.
    function automatic int unsigned num_banks(input int unsigned depth);
        return (depth + LUT_ENTRIES - 1) / LUT_ENTRIES;
    endfunction

    // INIT word for the LUT6 producing bit bit_idx of bank bank; entries at or
    // beyond depth read as 0.
    function automatic logic [63:0] lut_init_bit(
        input logic [INIT_MAX_W-1:0] init_value,
        input int unsigned           data_w,
        input int unsigned           depth,
        input int unsigned           bank,
        input int unsigned           bit_idx
    );
        logic [63:0] init;
        int unsigned e;
        init = '0;
        for (int unsigned i = 0; i < LUT_ENTRIES; i++) begin
            e = bank * LUT_ENTRIES + i;
            if (e < depth) begin
                init[i] = init_value[data_w * e + bit_idx];
            end
        end
        return init;
    endfunction

endpackage

// File: rtl/lut6_rom_bank.sv
// One 64 x DATA_W ROM bank: a LUT6 per output bit, all sharing the 6-bit index.
module lut6_rom_bank
    import ibf_pex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned BANK   = 0,
    parameter logic [DATA_W*DEPTH-1:0] INIT_VALUE = '0
) (
    input  logic [5:0]        addr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [INIT_MAX_W-1:0] INIT_EXT = INIT_MAX_W'(INIT_VALUE);

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        localparam logic [63:0] LUT_INIT = lut_init_bit(INIT_EXT, DATA_W, DEPTH, BANK, b);
        // LUT6 cell: INIT table indexed by I5..I0.
        assign rdata[b] = LUT_INIT[addr];
    end

endmodule

// File: rtl/lut_rom_lookup_pipe.sv
// Pipelined constant-lookup ROM: LUT6 banks, registered bank outputs, registered
// bank mux, valid/ready handshake with backpressure, tag sideband, range check
// and a saturating lookup counter.
module lut_rom_lookup_pipe
    import ibf_pex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 96,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned TAG_W  = 8,
    parameter logic [DATA_W*DEPTH-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [31:0]       lookup_cnt
);

    localparam int unsigned NUM_BANKS = num_banks(DEPTH);
    localparam int unsigned SEL_W     = (ADDR_W > 6) ? ADDR_W - 6 : 1;

    logic [5:0]        lut_addr;
    logic [SEL_W-1:0]  bank_sel;
    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    logic              s1_valid;
    logic [SEL_W-1:0]  s1_sel;
    logic              s1_err;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_bank [NUM_BANKS];

    logic [DATA_W-1:0] s2_data;
    logic              adv2;
    logic              accept;
    logic              in_err;
    logic [31:0]       cnt_q;

    if (ADDR_W > 6) begin : g_sel
        assign lut_addr = in_addr[5:0];
        assign bank_sel = in_addr[ADDR_W-1:6];
    end else begin : g_nosel
        assign lut_addr = 6'(in_addr);
        assign bank_sel = '0;
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        lut6_rom_bank #(
            .DATA_W     (DATA_W),
            .DEPTH      (DEPTH),
            .BANK       (g),
            .INIT_VALUE (INIT_VALUE)
        ) u_bank (
            .addr  (lut_addr),
            .rdata (bank_rdata[g])
        );
    end

    assign in_err     = 32'(in_addr) >= DEPTH;
    assign adv2       = !out_valid || out_ready;
    assign in_ready   = !s1_valid || adv2;
    assign accept     = in_valid && in_ready;
    assign lookup_cnt = cnt_q;

    // Bank mux; out-of-range select or err yields zero data.
    always_comb begin
        s2_data = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (32'(s1_sel) == b) begin
                s2_data = s1_bank[b];
            end
        end
        if (s1_err) begin
            s2_data = '0;
        end
    end

    // Stage 1: capture all bank outputs and sideband on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sel   <= '0;
            s1_err   <= 1'b0;
            s1_tag   <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                s1_bank[b] <= '0;
            end
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_sel   <= bank_sel;
            s1_err   <= in_err;
            s1_tag   <= in_tag;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                s1_bank[b] <= bank_rdata[b];
            end
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: output register, only updated when the consumer side can move.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (s1_valid && adv2) begin
            out_valid <= 1'b1;
            out_data  <= s2_data;
            out_tag   <= s1_tag;
            out_err   <= s1_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of accepted requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_lut_rom_lookup_pipe.sv
// Self-checking bench for lut_rom_lookup_pipe: directed cases plus randomized
// handshake traffic against an in-order reference queue.
`timescale 1ns/1ps
module tb_lut_rom_lookup_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 96;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned TAG_W  = 8;

    function automatic logic [DATA_W*DEPTH-1:0] mk_init();
        logic [DATA_W*DEPTH-1:0] r;
        r = '0;
        for (int e = 0; e < DEPTH; e++) begin
            r[DATA_W*e +: DATA_W] = 32'hA500_0000 + 32'(e);
        end
        return r;
    endfunction

    localparam logic [DATA_W*DEPTH-1:0] INIT = mk_init();

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;
    logic [31:0]       lookup_cnt;

    lut_rom_lookup_pipe #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .TAG_W      (TAG_W),
        .INIT_VALUE (INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .lookup_cnt (lookup_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] acc_cnt = '0;
    int          accepts = 0;
    int          pops = 0;
    logic        last_ov;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference ROM: entry e is 0xA5000000+e below DEPTH, else error with zero data.
    function automatic exp_t ref_lookup(input int unsigned a, input logic [TAG_W-1:0] t);
        exp_t r;
        r.tag = t;
        if (a < DEPTH) begin
            r.data = 32'hA500_0000 + a;
            r.err  = 1'b0;
        end else begin
            r.data = '0;
            r.err  = 1'b1;
        end
        return r;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the settled
    // outputs against the reference queue, then account for the handshakes
    // that the next rising edge will perform.
    task automatic step(input logic v, input logic [ADDR_W-1:0] a,
                        input logic [TAG_W-1:0] t, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_addr   = a;
        in_tag    = t;
        out_ready = ordy;
        #1;
        last_ov = out_valid;
        chk("in_ready", in_ready, !(sb.size() == 2 && !ordy));
        chk("lookup_cnt", lookup_cnt, acc_cnt);
        if (sb.size() == 0) begin
            chk("idle_out_valid", out_valid, 1'b0);
        end
        if (out_valid && sb.size() != 0) begin
            e = sb[0];
            chk("out_data", out_data, e.data);
            chk("out_tag", out_tag, e.tag);
            chk("out_err", out_err, e.err);
            if (ordy) begin
                void'(sb.pop_front());
                pops++;
            end
        end
        if (v && in_ready) begin
            sb.push_back(ref_lookup(a, t));
            accepts++;
            if (acc_cnt != 32'hFFFF_FFFF) acc_cnt = acc_cnt + 1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
        chk("drained", sb.size(), 0);
    endtask

    initial begin
        int a0;
        int p0;
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int p0;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_cnt", lookup_cnt, '0);
        @(negedge clk);
        rst = 1'b1;

        // Full stream 0..95, back-to-back, latency 2
        p0 = pops;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) step(1'b1, ADDR_W'(i), TAG_W'(i) ^ 8'h5A, 1'b1);
            else           step(1'b0, '0, '0, 1'b1);
            if (i == 1) chk("lat_not_yet", last_ov, 1'b0);
            if (i >= 2) chk("b2b_valid", last_ov, 1'b1);
        end
        chk("stream_pops", pops - p0, DEPTH);
        drain();

        // Out of range and bank boundary
        step(1'b1, 7'd100, 8'h11, 1'b1);
        step(1'b1, 7'd63, 8'h22, 1'b1);
        step(1'b1, 7'd64, 8'h33, 1'b1);
        step(1'b1, 7'd127, 8'h44, 1'b1);
        step(1'b1, 7'd95, 8'h55, 1'b1);
        step(1'b1, 7'd96, 8'h66, 1'b1);
        drain();

        // Backpressure: 5 cycles of out_ready=0 with in_valid=1
        a0 = accepts;
        for (int i = 0; i < 5; i++) step(1'b1, ADDR_W'(10 + i), TAG_W'(i), 1'b0);
        chk("stall_accepts", accepts - a0, 2);
        chk("stall_in_ready", in_ready, 1'b0);
        p0 = pops;
        drain();
        chk("stall_pops", pops - p0, 2);

        // Randomized handshake traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 127)),
                 TAG_W'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        drain();
        chk("rand_cnt", lookup_cnt, acc_cnt);

        // Reset with two lookups in flight
        step(1'b1, 7'd5, 8'hA1, 1'b0);
        step(1'b1, 7'd6, 8'hA2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_cnt", lookup_cnt, '0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        sb.delete();
        acc_cnt = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1);

        // Counter saturation
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        acc_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(1'b1, ADDR_W'(i), TAG_W'(i), 1'b1);
        drain();
        chk("sat_cnt", lookup_cnt, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
